dcache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache. It serves the memory stage through `dcache_if` (slave side) and refills from, or writes through to, a word-wide backing-memory port. Loads return byte, half or word data, already lane-aligned and sign- or zero-extended. Stores update a hit line and always write through to memory.

---
 rtl/dcache.sv | 192 +++++++++++++++++++
 tb/tb_dcache.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a word-wide
// backing-memory port; loads return lane-aligned, sign/zero-extended data.
module dcache #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic        write_en,
  input  logic [31:0] write_data,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic        resp_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);

  localparam int WB = $clog2(LINE_WORDS);
  localparam int LB = $clog2(LINES);
  localparam int TB = 30 - WB - LB;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [WB-1:0] LAST_WORD = WB'(LINE_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REFILL, S_WRITE, S_DONE} state_t;

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] sz, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_B:    r = {{24{sgn & b[7]}}, b};
      SZ_H:    r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [31:0] d, input logic [1:0] sz);
    logic [31:0] r;
    case (sz)
      SZ_B:    r = {4{d[7:0]}};
      SZ_H:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] off, input logic [1:0] sz);
    logic [3:0] r;
    case (sz)
      SZ_B:    r = 4'b0001 << off;
      SZ_H:    r = off[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  state_t        state, state_nx;
  logic [31:0]   addr_q, wdata_q, resp_data_q;
  logic          we_q, sign_q, pending;
  logic [1:0]    size_q;
  logic [WB-1:0] cnt;
  logic [LINES-1:0] valid_q;
  logic [TB-1:0] tag_mem [LINES];
  logic [31:0]   data_mem [LINES*LINE_WORDS];

  logic [LB-1:0] line_idx;
  logic [WB-1:0] word_idx;
  logic [TB-1:0] tag_in;
  logic          hit, rd_capture;
  logic [31:0]   cur_word, st_data;
  logic [3:0]    st_strb;

  assign line_idx   = addr_q[2+WB +: LB];
  assign word_idx   = addr_q[2 +: WB];
  assign tag_in     = addr_q[31 -: TB];
  assign hit        = valid_q[line_idx] && (tag_mem[line_idx] == tag_in);
  assign cur_word   = data_mem[{line_idx, word_idx}];
  assign st_data    = store_lanes(wdata_q, size_q);
  assign st_strb    = store_strb(addr_q[1:0], size_q);
  // Read data counts only while a read is outstanding; stray pulses are dropped.
  assign rd_capture = (state == S_REFILL) && pending && mem_resp_valid;

  assign resp_ready = (state == S_IDLE);
  assign resp_valid = (state == S_DONE);
  assign resp_data  = resp_data_q;

  always_comb begin
    state_nx      = state;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_wstrb = '0;
    case (state)
      S_IDLE:   if (req_valid) state_nx = S_LOOKUP;
      S_LOOKUP: begin
        if (we_q)     state_nx = S_WRITE;
        else if (hit) state_nx = S_DONE;
        else          state_nx = S_REFILL;
      end
      S_REFILL: begin
        mem_req_valid = !pending;
        mem_req_addr  = {addr_q[31:2+WB], cnt, 2'b00};
        if (rd_capture && cnt == LAST_WORD) state_nx = S_LOOKUP;
      end
      S_WRITE: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {addr_q[31:2], 2'b00};
        mem_req_wdata = st_data;
        mem_req_wstrb = st_strb;
        if (mem_req_ready) state_nx = S_DONE;
      end
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      sign_q      <= 1'b0;
      valid_q     <= '0;
      cnt         <= '0;
      pending     <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          wdata_q <= write_data;
          we_q    <= write_en;
          size_q  <= size;
          sign_q  <= sign;
        end
        S_LOOKUP: if (!we_q) begin
          if (hit) begin
            resp_data_q <= load_extract(cur_word, addr_q[1:0], size_q, sign_q);
          end else begin
            // Invalidate up front so an interrupted refill never looks like a hit.
            valid_q[line_idx] <= 1'b0;
            cnt               <= '0;
            pending           <= 1'b0;
          end
        end
        S_REFILL: begin
          if (mem_req_valid && mem_req_ready) pending <= 1'b1;
          if (rd_capture) begin
            pending <= 1'b0;
            cnt     <= cnt + WB'(1);
            if (cnt == LAST_WORD) valid_q[line_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (rd_capture) begin
      data_mem[{line_idx, cnt}] <= mem_resp_rdata;
      if (cnt == LAST_WORD) tag_mem[line_idx] <= tag_in;
    end
    if (state == S_LOOKUP && we_q && hit) begin
      for (int i = 0; i < 4; i++) begin
        if (st_strb[i]) data_mem[{line_idx, word_idx}][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: randomized and directed loads/stores against a
// reference model of memory contents and line residency.
module tb_dcache;
  localparam int LINES = 16;
  localparam int LINE_WORDS = 4;
  localparam int LINE_BYTES = LINE_WORDS * 4;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        write_en = 1'b0;
  logic [31:0] write_data = '0;
  logic [1:0]  size = '0;
  logic        sign = 1'b0;
  logic        resp_ready, resp_valid;
  logic [31:0] resp_data;
  logic        mem_req_valid, mem_req_we;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;

  dcache #(.LINES(LINES), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .write_en(write_en), .write_data(write_data), .size(size), .sign(sign),
    .resp_ready(resp_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          reads;
    int          writes;
    logic [31:0] base;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int n_checks = 0, n_pass = 0;
  int acc_cyc = 0;
  bit stall_mode = 0;
  int hold_cnt = 0;

  // Reference model state
  logic [31:0] ref_mem [int];
  logic [31:0] bmem [int];
  bit          ref_valid [LINES];
  int unsigned ref_tag [LINES];
  logic [31:0] last_load = '0;

  function automatic logic [31:0] init_word(int key);
    return (32'(key) * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction
  function automatic logic [31:0] ref_get(int key);
    return ref_mem.exists(key) ? ref_mem[key] : init_word(key);
  endfunction
  function automatic logic [31:0] bget(int key);
    return bmem.exists(key) ? bmem[key] : init_word(key);
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] w, int off, logic [1:0] sz, logic sg);
    logic [31:0] v;
    if (sz == SZ_B) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (sg && v >= 32'd128) v = v - 32'd256;
    end else if (sz == SZ_H) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (sg && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_reset_outputs();
    chk("rst_resp_ready", 32'(resp_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_req_we", 32'(mem_req_we), 32'd0);
    chk("rst_mem_req_addr", mem_req_addr, 32'd0);
    chk("rst_mem_req_wdata", mem_req_wdata, 32'd0);
    chk("rst_mem_req_wstrb", 32'(mem_req_wstrb), 32'd0);
  endtask

  task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd,
                       input logic [1:0] sz, input logic sg, input bit wait_done);
    exp_t e;
    int line, off, key, tmo;
    int unsigned tag;
    bit hit;
    logic [31:0] w;
    line = int'((a / LINE_BYTES) % LINES);
    tag  = a / (LINES * LINE_BYTES);
    off  = int'(a % 4);
    key  = int'(a >> 2);
    hit  = ref_valid[line] && ref_tag[line] == tag;
    e.base = a - (a % LINE_BYTES);
    e.waddr = a - (a % 4);
    e.wdata = '0;
    e.wstrb = '0;
    if (!we) begin
      e.data   = ref_load(ref_get(key), off, sz, sg);
      e.reads  = hit ? 0 : LINE_WORDS;
      e.writes = 0;
      e.lat    = hit ? 1 : 2 * LINE_WORDS + 2;
      ref_valid[line] = 1;
      ref_tag[line]   = tag;
      last_load       = e.data;
    end else begin
      if (sz == SZ_B) begin
        e.wdata = (wd & 32'hFF) * 32'h01010101;
        e.wstrb = 4'(1 << off);
      end else if (sz == SZ_H) begin
        e.wdata = (wd & 32'hFFFF) * 32'h00010001;
        e.wstrb = (off >= 2) ? 4'b1100 : 4'b0011;
      end else begin
        e.wdata = wd;
        e.wstrb = 4'b1111;
      end
      w = ref_get(key);
      for (int i = 0; i < 4; i++) if (e.wstrb[i]) w[8*i +: 8] = e.wdata[8*i +: 8];
      ref_mem[key] = w;
      e.data   = last_load;
      e.reads  = 0;
      e.writes = 1;
      e.lat    = 2;
    end
    if (stall_mode || hold_cnt > 0) e.lat = -1;

    tmo = 0;
    do begin
      @(negedge clk);
      tmo++;
    end while (!resp_ready && tmo < 50);
    if (!resp_ready) begin
      $display("FAIL accept_timeout: resp_ready stayed 0");
      $fatal(1, "bench stopped");
    end
    sbq.push_back(e);
    req_addr = a; write_en = we; write_data = wd; size = sz; sign = sg;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    // Junk while busy: must be ignored until resp_ready returns.
    req_valid = 1'($urandom % 2);
    req_addr = $urandom; write_en = 1'($urandom % 2); write_data = $urandom;
    size = 2'($urandom % 3); sign = 1'($urandom % 2);
    if (wait_done) begin
      tmo = 0;
      do begin
        @(negedge clk);
        tmo++;
      end while (!resp_valid && tmo < 500);
      req_valid = 1'b0;
      if (!resp_valid) begin
        $display("FAIL resp_timeout: no resp_valid for addr 0x%08h", a);
        $fatal(1, "bench stopped");
      end
    end
  endtask

  // Backing memory
  initial begin : memory
    bit          do_acc, acc_we, rd_due;
    logic [31:0] acc_addr, acc_wdata;
    logic [3:0]  acc_strb;
    int          rd_key, rd_wait;
    logic [31:0] w;
    rd_due = 0; rd_key = 0; rd_wait = 0;
    forever begin
      @(negedge clk);
      do_acc = rst_n && mem_req_valid && mem_req_ready;
      acc_we = mem_req_we; acc_addr = mem_req_addr;
      acc_wdata = mem_req_wdata; acc_strb = mem_req_wstrb;
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      if (!rst_n) begin
        rd_due = 0;
      end else begin
        if (do_acc) begin
          if (acc_we) begin
            w = bget(int'(acc_addr >> 2));
            for (int i = 0; i < 4; i++) if (acc_strb[i]) w[8*i +: 8] = acc_wdata[8*i +: 8];
            bmem[int'(acc_addr >> 2)] = w;
          end else begin
            rd_due = 1;
            rd_key = int'(acc_addr >> 2);
            rd_wait = stall_mode ? int'($urandom % 3) : 0;
          end
        end
        if (rd_due) begin
          if (rd_wait == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = bget(rd_key);
            rd_due = 0;
          end else begin
            rd_wait--;
          end
        end else if (stall_mode && ($urandom % 8) == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = $urandom;
        end
      end
      if (hold_cnt > 0) begin
        mem_req_ready = 1'b0;
        hold_cnt--;
      end else begin
        mem_req_ready = stall_mode ? (($urandom % 4) != 0) : 1'b1;
      end
    end
  end

  // Monitor / scoreboard checker
  initial begin : monitor
    int rd_seen, wr_seen;
    bit prev_stall;
    logic [31:0] prev_addr;
    exp_t e;
    rd_seen = 0; wr_seen = 0; prev_stall = 0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_seen = 0; wr_seen = 0; prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("stall_req_valid", 32'(mem_req_valid), 32'd1);
          chk("stall_req_addr", mem_req_addr, prev_addr);
        end
        prev_stall = mem_req_valid && !mem_req_ready;
        prev_addr = mem_req_addr;
        if (mem_req_valid && mem_req_ready) begin
          if (sbq.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_mem_req: addr 0x%08h with no request pending", mem_req_addr);
          end else if (mem_req_we) begin
            wr_seen++;
            chk("wr_addr", mem_req_addr, sbq[0].waddr);
            chk("wr_data", mem_req_wdata, sbq[0].wdata);
            chk("wr_strb", 32'(mem_req_wstrb), 32'(sbq[0].wstrb));
          end else begin
            chk("rd_addr", mem_req_addr, sbq[0].base + 32'(rd_seen * 4));
            rd_seen++;
          end
        end
        if (resp_valid) begin
          if (sbq.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_resp: resp_data 0x%08h with empty scoreboard", resp_data);
          end else begin
            e = sbq.pop_front();
            chk("resp_data", resp_data, e.data);
            chk("resp_ready_low", 32'(resp_ready), 32'd0);
            chk("read_count", 32'(rd_seen), 32'(e.reads));
            chk("write_count", 32'(wr_seen), 32'(e.writes));
            if (e.lat >= 0) chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
          end
          rd_seen = 0; wr_seen = 0;
        end
      end
    end
  end

  initial begin : stimulus
    int tmo;
    logic [31:0] a;
    for (int i = 0; i < LINES; i++) begin ref_valid[i] = 0; ref_tag[i] = 0; end
    for (int i = 0; i < 4; i++) begin
      ref_mem[32'h40 + i] = 32'h11111111 * (i + 1);
      bmem[32'h40 + i]    = 32'h11111111 * (i + 1);
    end
    ref_mem[32'hF0] = 32'h80FF7F01;
    bmem[32'hF0]    = 32'h80FF7F01;

    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Cold load then hit
    issue(32'h100, 0, 0, SZ_W, 0, 1);
    issue(32'h104, 0, 0, SZ_W, 0, 1);
    // Extension on word 0x80FF7F01 at 0x3C0
    issue(32'h3C0, 0, 0, SZ_W, 0, 1);
    issue(32'h3C3, 0, 0, SZ_B, 1, 1);
    issue(32'h3C3, 0, 0, SZ_B, 0, 1);
    issue(32'h3C2, 0, 0, SZ_H, 1, 1);
    issue(32'h3C0, 0, 0, SZ_H, 0, 1);
    // Store hit, then merged reload
    issue(32'h101, 1, 32'h000000AB, SZ_B, 0, 1);
    issue(32'h100, 0, 0, SZ_W, 0, 1);
    // Store miss (no allocate), then load misses
    issue(32'h20E, 1, 32'h0000BEEF, SZ_H, 0, 1);
    issue(32'h20C, 0, 0, SZ_W, 0, 1);
    // Conflict eviction on line 0
    issue(32'h100, 0, 0, SZ_W, 0, 1);
    issue(32'h100 + LINES * LINE_BYTES, 0, 0, SZ_W, 0, 1);
    issue(32'h100, 0, 0, SZ_W, 0, 1);
    // Memory stall
    hold_cnt = 12;
    issue(32'h400, 0, 0, SZ_W, 0, 1);
    hold_cnt = 0;

    // Reset during the third refill word
    issue(32'h500, 0, 0, SZ_W, 0, 0);
    req_valid = 1'b0;
    tmo = 0;
    do begin
      @(negedge clk);
      tmo++;
    end while (!(mem_req_valid && mem_req_addr == 32'h508) && tmo < 100);
    if (!(mem_req_valid && mem_req_addr == 32'h508)) begin
      $display("FAIL third_refill_timeout: read of 0x508 never requested");
      $fatal(1, "bench stopped");
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    sbq.delete();
    for (int i = 0; i < LINES; i++) ref_valid[i] = 0;
    last_load = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(32'h500, 0, 0, SZ_W, 0, 1);

    // Randomized traffic: latency checked first, then with random stalls
    for (int i = 0; i < 300; i++) begin
      stall_mode = (i >= 100);
      a = ($urandom & 32'h3FF) | ((($urandom % 2) == 1) ? 32'h8000_0000 : 32'h0);
      issue(a, 1'(($urandom % 3) == 0), $urandom, 2'($urandom % 3), 1'($urandom % 2), 1);
    end
    stall_mode = 0;

    repeat (5) @(negedge clk);
    if (sbq.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
